// File: rtl/cpu_mem_xfer_ctrl.sv
// cpu_mem_xfer_ctrl: host-side burst controller for the coprocessor CPU memory port,
// owning the port via cpu_interrupt while streaming words in or out.
module cpu_mem_xfer_ctrl #(
    parameter int DW     = 60,
    parameter int AW     = 11,
    parameter int RD_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [2:0]    cmd_mb_sel,
    input  logic [3:0]    cmd_mem_sel,
    input  logic [AW-1:0] cmd_addr,
    input  logic [AW:0]   cmd_len,
    input  logic          copro_busy,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_valid,
    output logic          wr_ready,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          xfer_done,
    output logic          cpu_interrupt,
    output logic          cpu_interrupt_all,
    output logic [2:0]    cpu_mb_sel,
    output logic [3:0]    cpu_mem_sel,
    output logic [AW-1:0] cpu_mem_addr,
    output logic [DW-1:0] cpu_mem_wr_data,
    output logic          cpu_mem_wr_en,
    input  logic [DW-1:0] cpu_mem_rd_data
);
    typedef enum logic [2:0] {IDLE, WAIT, SETUP, XFER, DRAIN, RELEASE, DONE} state_t;
    state_t state, state_n;
    logic wr_mode;
    logic [AW:0] len, cnt;
    logic [AW-1:0] ptr;
    logic [RD_LAT:0] inflight;
    logic acc, issue;

    assign cmd_ready = (state == IDLE) & ~rst;
    assign wr_ready = (state == XFER) && wr_mode && (cnt != len);
    assign acc = wr_valid & wr_ready;
    // read addresses are registered one cycle ahead, so issuing starts in SETUP
    assign issue = !wr_mode && (state == SETUP || state == XFER) && (cnt != len);
    assign cpu_interrupt_all = 1'b0;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (cmd_valid) state_n = (cmd_len == '0) ? DONE : copro_busy ? WAIT : SETUP;
            WAIT:    state_n = copro_busy ? WAIT : SETUP;
            SETUP:   state_n = XFER;
            XFER:    state_n = wr_mode ? ((acc && cnt + 1'b1 == len) ? RELEASE : XFER)
                                       : ((cnt == len) ? DRAIN : XFER);
            DRAIN:   state_n = (inflight == '0) ? DONE : DRAIN;
            RELEASE: state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_mode         <= 1'b0;
            len             <= '0;
            cnt             <= '0;
            ptr             <= '0;
            inflight        <= '0;
            rd_data         <= '0;
            rd_valid        <= 1'b0;
            xfer_done       <= 1'b0;
            cpu_interrupt   <= 1'b0;
            cpu_mb_sel      <= '0;
            cpu_mem_sel     <= '0;
            cpu_mem_addr    <= '0;
            cpu_mem_wr_data <= '0;
            cpu_mem_wr_en   <= 1'b0;
        end else begin
            if (cmd_valid && state == IDLE) begin
                wr_mode     <= cmd_write;
                len         <= cmd_len;
                cnt         <= '0;
                ptr         <= cmd_addr;
                cpu_mb_sel  <= cmd_mb_sel;
                cpu_mem_sel <= cmd_mem_sel;
            end
            if (acc || issue) begin
                cpu_mem_addr <= ptr;
                ptr          <= ptr + 1'b1;
                cnt          <= cnt + 1'b1;
            end
            cpu_mem_wr_en <= acc;
            if (acc) cpu_mem_wr_data <= wr_data;
            inflight <= {inflight[RD_LAT-1:0], issue};
            rd_valid <= inflight[RD_LAT];
            if (inflight[RD_LAT]) rd_data <= cpu_mem_rd_data;
            cpu_interrupt <= state_n inside {SETUP, XFER, DRAIN, RELEASE};
            xfer_done     <= state_n == DONE;
        end
    end
endmodule

// File: doc/cpu_mem_xfer_ctrl.md
# cpu_mem_xfer_ctrl

Host-side transfer controller for the coprocessor's CPU memory port (`cpu_interrupt`, `cpu_mb_sel`, `cpu_mem_sel`, `cpu_mem_addr`, `cpu_mem_wr_*`, `cpu_mem_rd_data`). It accepts one burst command at a time and waits until the coprocessor is idle. It then asserts `cpu_interrupt`, streams up to 2048 words in or out with an auto-incrementing, wrapping address, compensates the memory read latency, and releases the port.

## Interface
- `DW`, 60, memory word width
- `AW`, 11, word address width (2048 words per memory)
- `RD_LAT`, 2, cycles from `cpu_mem_addr` presented to `cpu_mem_rd_data` valid (≥1)
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high
- `cmd_valid`  in  1  command request
- `cmd_ready`  out  1  high in IDLE only
- `cmd_write`  in  1  1 = write burst, 0 = read burst
- `cmd_mb_sel`  in  3  memory-bank select
- `cmd_mem_sel`  in  4  memory select within bank
- `cmd_addr`  in  AW  start word address
- `cmd_len`  in  AW+1  word count, 0..2048
- `copro_busy`  in  1  coprocessor executing an instruction
- `wr_data`  in  DW  write stream data
- `wr_valid`  in  1  write stream valid
- `wr_ready`  out  1  write stream ready
- `rd_data`  out  DW  read stream data, no backpressure
- `rd_valid`  out  1  read stream valid
- `xfer_done`  out  1  one-cycle pulse when a burst completes
- `cpu_interrupt`  out  1  memory-port ownership to host
- `cpu_interrupt_all`  out  1  tied 0
- `cpu_mb_sel`  out  3  registered copy of `cmd_mb_sel`
- `cpu_mem_sel`  out  4  registered copy of `cmd_mem_sel`
- `cpu_mem_addr`  out  AW  word address
- `cpu_mem_wr_data`  out  DW  write data
- `cpu_mem_wr_en`  out  1  write strobe
- `cpu_mem_rd_data`  in  DW  read data from coprocessor

## Operation
- **States:**
  - IDLE: on `cmd_valid`, latch the command. Go to DONE if `cmd_len`=0, WAIT if `copro_busy`, otherwise SETUP.
  - WAIT: stay while `copro_busy`=1, then go to SETUP.
  - SETUP: exactly one cycle. `cpu_interrupt`=1, selects driven, no access.
  - XFER: one access per beat.
  - DRAIN: reads only, until the read pipeline is empty.
  - RELEASE: writes only, one cycle, covering the last `cpu_mem_wr_en`.
  - DONE: one cycle. `cpu_interrupt`=0, `xfer_done`=1. Then IDLE.
- **Write XFER:**
  - `wr_ready`=1 while fewer than `cmd_len` beats have been accepted.
  - A beat accepted in cycle k (`wr_valid & wr_ready`) appears in cycle k+1 on `cpu_mem_wr_en`=1, `cpu_mem_addr`, `cpu_mem_wr_data`.
  - `wr_valid` gaps insert idle cycles. `cpu_interrupt` stays 1 throughout.
- **Read XFER:**
  - One address per cycle, no gaps: `cmd_len` consecutive cycles.
  - A valid-bit shift register of depth `RD_LAT`+1 tracks in-flight reads.
  - For an address presented in cycle a: `rd_data` = `cpu_mem_rd_data` sampled at a+`RD_LAT`, and `rd_valid`=1 in cycle a+`RD_LAT`+1.
- **Address arithmetic:** address n = (`cmd_addr`+n) mod 2^`AW`, so 2047 wraps to 0.
- **`copro_busy`:** sampled only in IDLE and WAIT; ignored once SETUP is entered.
- **Selects:** `cpu_mb_sel` and `cpu_mem_sel` hold their values from SETUP through DONE.
- **Reset mid-burst:** all state and outputs are cleared immediately. In-flight reads are discarded and no `xfer_done` is issued.

## Timing
- **Reset values:** every output is 0, state is IDLE, `cmd_ready`=1 once `rst` is low.
- All outputs to the coprocessor are registered. `wr_ready` and `cmd_ready` are decoded from state and counters.
- Let T be the cycle of the `cmd_valid & cmd_ready` handshake.
- **Non-busy path:** SETUP is cycle T+1.
- **Busy path:** SETUP is the cycle after the first WAIT cycle that samples `copro_busy`=0.
- **Write, `wr_valid` held high:**
  - beats accepted T+2 .. T+1+N
  - `cpu_mem_wr_en` T+3 .. T+2+N
  - `xfer_done` at T+3+N, with `cpu_interrupt` low in the same cycle.
- **Read:**
  - addresses T+2 .. T+1+N
  - `rd_valid` T+3+`RD_LAT` .. T+2+N+`RD_LAT`
  - `xfer_done` at T+3+N+`RD_LAT`
- **`cmd_len`=0:** `xfer_done` at T+1; `cpu_interrupt` never asserts.
- **Back-to-back commands:** the next command is accepted at the earliest in the cycle after DONE.

## Test plan
- **Full write:** mb 0, mem 4, addr 0, len 2048, `wr_data`=i, `wr_valid` held high -> 2048 strobes with addr=data=i at T+3..T+2050; `cpu_interrupt` high from T+1 to T+2050; `xfer_done` at T+2051.
- **Wrapping read:** memory preloaded with addr, read addr 2046, len 4, `RD_LAT`=2 -> `rd_data` 2046, 2047, 0, 1 on `rd_valid` T+5..T+8; `xfer_done` T+9.
- **Stalled write stream:** len 3, `wr_valid` pattern 1,0,0,1,1 -> strobes only for the valid beats, addresses consecutive; `xfer_done` one cycle after the third strobe.
- **Busy hold:** `copro_busy`=1 for 10 cycles after T -> `cpu_interrupt` stays 0 through the busy window; SETUP follows the first not-busy sample. A `copro_busy` rise during XFER changes nothing.
- **Zero length:** len 0 -> `xfer_done` at T+1, no `cpu_interrupt`, no strobes.
- **Reset mid-burst:** `rst` asserted mid-read of len 16 -> all outputs 0 asynchronously, no `rd_valid` or `xfer_done` after release, `cmd_ready`=1.
